// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a two-entry skid buffer, synchronous
// flush and a saturating back-pressure counter; in_ready never sees out_ready combinationally.
module pipe_stage_skid #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned       CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept_s;
    logic             take_s;

    assign accept_s = in_valid & in_ready_q;
    assign take_s   = out_valid_q & out_ready;

    // Next-state and payload steering; flush overrides every transfer but leaves payloads untouched.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_d  = in_data;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (accept_s && take_s) begin
                        main_d  = in_data;
                        state_d = ST_BUSY;
                    end else if (accept_s) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (take_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (take_s) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_comb begin
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // Stall counter saturates instead of wrapping; flush does not affect it.
    always_comb begin
        if (out_valid_q && !out_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, payload and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            cnt_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks of pipe_stage_skid against hand-computed values
// and a small queue model; a second instance with a 3-bit counter covers saturation.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [7:0]  in_data, out_data;
    logic [15:0] stall_cnt;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush;
    logic [7:0]  s_in_data, s_out_data;
    logic [2:0]  s_stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(8), .RESET_VAL(8'hE5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(3)) dut_s (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .flush(s_flush), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  q[$];
    int unsigned stall_m;
    logic        m_take, m_acc;

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = 8'h00;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_flush = 1'b0; s_in_data = 8'h00;

        // Reset values
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", {24'd0, out_data}, 32'hE5);
        check("rst_stall", {16'd0, stall_cnt}, 32'd0);
        reset = 1'b1;
        step();

        // Streaming at full throughput
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'h11 + 8'(i);
            step();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_data", {24'd0, out_data}, 32'h11 + i);
            check("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", {31'd0, out_valid}, 32'd0);
        check("stream_stall", {16'd0, stall_cnt}, 32'd0);

        // Back-pressure: two absorbed, third held off
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h0A;
        step();
        check("bp_a_data", {24'd0, out_data}, 32'h0A);
        check("bp_a_ready", {31'd0, in_ready}, 32'd1);
        in_data = 8'h0B;
        step();
        check("bp_b_ready", {31'd0, in_ready}, 32'd0);
        check("bp_b_data", {24'd0, out_data}, 32'h0A);
        in_data = 8'h0C;
        step();
        check("bp_c_ready", {31'd0, in_ready}, 32'd0);
        check("bp_c_data", {24'd0, out_data}, 32'h0A);
        check("bp_stall", {16'd0, stall_cnt}, 32'd2);
        out_ready = 1'b1;
        step();
        check("bp_out_b", {24'd0, out_data}, 32'h0B);
        check("bp_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_out_c", {24'd0, out_data}, 32'h0C);
        check("bp_out_c_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        check("bp_drain", {31'd0, out_valid}, 32'd0);
        check("bp_stall_hold", {16'd0, stall_cnt}, 32'd2);

        // Flush from FULL discards the held entries and the concurrent offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h05;
        step();
        in_data = 8'h06;
        step();
        check("fl_full", {31'd0, in_ready}, 32'd0);
        in_data = 8'h07;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_ready", {31'd0, in_ready}, 32'd1);
        check("fl_data_kept", {24'd0, out_data}, 32'h05);
        step();
        check("fl_still_empty", {31'd0, out_valid}, 32'd0);
        check("fl_stall", {16'd0, stall_cnt}, 32'd4);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h08;
        step();
        in_valid = 1'b0;
        check("fl_next_data", {24'd0, out_data}, 32'h08);
        step();
        check("fl_next_drain", {31'd0, out_valid}, 32'd0);

        // Counter saturation on the 3-bit instance
        s_in_valid = 1'b1;
        s_in_data  = 8'h01;
        step();
        s_in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("sat_cnt", {29'd0, s_stall_cnt}, (i < 7) ? i : 7);
        end

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h21;
        step();
        in_data = 8'h22;
        step();
        in_valid = 1'b0;
        check("ar_full", {31'd0, in_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_ready", {31'd0, in_ready}, 32'd1);
        check("ar_data", {24'd0, out_data}, 32'hE5);
        check("ar_stall", {16'd0, stall_cnt}, 32'd0);
        check("ar_stall_s", {29'd0, s_stall_cnt}, 32'd0);
        #2;
        reset = 1'b1;
        step();
        check("ar_release", {31'd0, out_valid}, 32'd0);

        // Random traffic against a queue model
        q.delete();
        stall_m = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = 8'($urandom_range(0, 255));
            #1;
            check("rnd_in_ready", {31'd0, in_ready}, (q.size() < 2) ? 32'd1 : 32'd0);
            m_take = (q.size() > 0) && out_ready;
            m_acc  = in_valid && (q.size() < 2);
            if ((q.size() > 0) && !out_ready && (stall_m < 65535)) stall_m++;
            @(posedge clk);
            if (flush) begin
                q.delete();
            end else begin
                if (m_take) void'(q.pop_front());
                if (m_acc) q.push_back(in_data);
            end
            #1;
            check("rnd_out_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
            if (q.size() > 0) check("rnd_out_data", {24'd0, out_data}, {24'd0, q[0]});
            check("rnd_stall", {16'd0, stall_cnt}, stall_m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, handshaked pipeline stage register that generalises the fixed-width, always-advancing inter-stage registers between the processor's pipeline stages. Each instance carries a WIDTH-bit bundle of stage signals (ALU result, write data, immediate, Rd, PC values, …) from one stage to the next. It adds valid/ready flow control, a two-entry skid buffer so `in_ready` has no combinational path from `out_ready`, a synchronous flush for branch/exception squash, and a saturating back-pressure counter for performance monitoring.

## Interface
- `WIDTH`, 32: payload width in bits, ≥1.
- `RESET_VAL`, 0: value of `out_data` after reset, WIDTH bits.
- `CNT_W`, 16: width of the stall counter, ≥1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; 0 = reset asserted.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  stage can accept; registered.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` is valid; registered.
- `out_ready`  in  1  downstream takes `out_data` this cycle.
- `out_data`  out  WIDTH  payload to the next stage; registered.
- `flush`  in  1  synchronous squash of all held entries.
- `stall_cnt`  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Accept = `in_valid & in_ready`. Take = `out_valid & out_ready`.
- Storage: main register (drives `out_data`) and skid register. States are EMPTY (0 entries), BUSY (main only) and FULL (main + skid).
- `out_valid` = state != EMPTY. `in_ready` = state != FULL. Both are decoded from state flops only.
- EMPTY: on accept, main ← `in_data` and go to BUSY. Otherwise stay.
- BUSY:
  - accept & take: main ← `in_data`, stay BUSY.
  - accept & !take: skid ← `in_data`, go to FULL.
  - take & !accept: go to EMPTY.
  - neither: hold.
- FULL: no accept is possible. On take, main ← skid and go to BUSY. Otherwise hold.
- Ordering is strict FIFO. No payload is duplicated or dropped except by flush.
- Flush has priority over all other events:
  - Next state is EMPTY.
  - Any accept in the flush cycle is discarded.
  - A take in the flush cycle completes normally downstream.
  - `out_data` keeps its last value; only the valid bits clear.
- `stall_cnt` increments by 1 in every cycle with `out_valid & !out_ready`, independent of flush.
  - Saturates at 2^CNT_W−1 with no wrap.
  - Cleared only by reset.
- Payload registers load only on the events above. They never change while held, which keeps data stable under back-pressure.

## Timing
- Reset (`reset`=0, async):
  - state = EMPTY, so `out_valid`=0 and `in_ready`=1.
  - `out_data` = RESET_VAL, skid register = RESET_VAL, `stall_cnt`=0.
  - Release is synchronous to the next `clk` edge.
- Latency: data accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (cycle N+1).
- Throughput: 1 transfer/cycle when `out_ready` is held high.
- Back-pressure: with `out_ready`=0 the stage absorbs 2 items. `in_ready` drops the cycle after the second accept.
- After `out_ready` returns to 1, `in_ready` returns to 1 one cycle after the first take.
- `in_ready`, `out_valid` and `out_data` change only at `clk` edges. The only combinational inputs are into next-state logic.
- Reset asserted mid-operation: all entries are lost immediately and outputs go to reset values asynchronously.
- Flush asserted in FULL with take: skid is discarded, next state is EMPTY.

## Test plan
- Reset: drive `reset`=0 mid-stream while FULL → `out_valid`=0, `in_ready`=1, `out_data`=RESET_VAL, `stall_cnt`=0 without waiting for a clock edge.
- Streaming: `out_ready`=1, send 0x11..0x18 on consecutive cycles → same 8 values out, each 1 cycle after accept, no gaps.
- Back-pressure: `out_ready`=0, offer 0xA, 0xB, 0xC → 0xA and 0xB accepted, `in_ready`=0 from the cycle after 0xB. Raise `out_ready` → 0xA, 0xB, 0xC delivered in order, and `stall_cnt` equals the number of stalled cycles.
- Flush: hold FULL with 0x5, 0x6, pulse `flush` with `in_valid`=1 and data 0x7 → next cycle EMPTY, `out_valid`=0. 0x7 never appears and `in_ready`=1.
- Counter saturation: `CNT_W`=3, `out_valid`=1, `out_ready`=0 for 10 cycles → `stall_cnt` goes 1…7 and stays at 7.
- Random: random `in_valid`/`out_ready`/rare `flush` for 10k cycles against a scoreboard model → order preserved, no drop or duplicate except flushed entries, and `in_ready` never depends on same-cycle `out_ready`.
